// File: rtl/pipe_pkg.sv
// Shared front-end pipeline types: fetch slot layout, skid-stage states
// and a helper sizing a packed multi-lane fetch group.
package pipe_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } fetch_slot_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  function automatic int group_bits(
    input int width,
    input int lanes
  );
    return lanes * (2 * width + 1);
  endfunction

endpackage

// File: rtl/stage_skid_buf.sv
// Generic 2-entry skid register: main feeds the outputs, skid catches
// the group that arrives while downstream stalls.
module stage_skid_buf
  import pipe_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          flush_in,
  input  logic          up_valid_in,
  output logic          up_ready_out,
  input  logic [DW-1:0] up_data_in,
  output logic          dn_valid_out,
  input  logic          dn_ready_in,
  output logic [DW-1:0] dn_data_out
);

  stage_state_e state_q, state_d;
  logic [DW-1:0] main_q, skid_q;
  logic acc, rel;
  logic ld_in, ld_skid, mv_skid;

  assign up_ready_out = (state_q != FULL);
  assign dn_valid_out = (state_q != EMPTY);
  assign dn_data_out  = main_q;

  assign acc = up_valid_in & up_ready_out;
  assign rel = dn_valid_out & dn_ready_in;

  always_comb begin
    state_d = state_q;
    ld_in   = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    if (flush_in) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = HALF;
            ld_in   = 1'b1;
          end
        end
        HALF: begin
          if (acc && rel) begin
            ld_in = 1'b1;
          end else if (acc) begin
            state_d = FULL;
            ld_skid = 1'b1;
          end else if (rel) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (rel) begin
            state_d = HALF;
            mv_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      unique case (1'b1)
        ld_in:   main_q <= up_data_in;
        mv_skid: main_q <= skid_q;
        default: ;
      endcase
      if (ld_skid) begin
        skid_q <= up_data_in;
      end
    end
  end

endmodule

// File: rtl/ifid_skid_stage.sv
// IF->ID multi-lane skid stage with flush; IFID_PERF_EN adds saturating
// stall/flush counters (ports tied to zero otherwise).
module ifid_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LANES     = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   flush_in,
  input  logic                   up_valid_in,
  output logic                   up_ready_out,
  input  logic [LANES*WIDTH-1:0] pc_in,
  input  logic [LANES*WIDTH-1:0] instr_in,
  input  logic [LANES-1:0]       lane_valid_in,
  output logic                   dn_valid_out,
  input  logic                   dn_ready_in,
  output logic [LANES*WIDTH-1:0] pc_out,
  output logic [LANES*WIDTH-1:0] instr_out,
  output logic [LANES-1:0]       lane_valid_out,
  output logic [CNT_WIDTH-1:0]   stall_cnt_out,
  output logic [CNT_WIDTH-1:0]   flush_cnt_out
);

  localparam int LW = LANES * WIDTH;
  localparam int GW = group_bits(WIDTH, LANES);

  logic [GW-1:0] grp_in, grp_out;

  assign grp_in = {lane_valid_in, instr_in, pc_in};

  stage_skid_buf #(
    .DW(GW)
  ) u_buf (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .flush_in    (flush_in),
    .up_valid_in (up_valid_in),
    .up_ready_out(up_ready_out),
    .up_data_in  (grp_in),
    .dn_valid_out(dn_valid_out),
    .dn_ready_in (dn_ready_in),
    .dn_data_out (grp_out)
  );

  // Stale payload may linger after a flush; lane valids must not.
  assign pc_out         = grp_out[LW-1:0];
  assign instr_out      = grp_out[2*LW-1:LW];
  assign lane_valid_out = grp_out[GW-1:2*LW] & {LANES{dn_valid_out}};

`ifdef IFID_PERF_EN
  logic [CNT_WIDTH-1:0] stall_q, flush_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (dn_valid_out && !dn_ready_in && stall_q != '1) begin
        stall_q <= stall_q + 1'b1;
      end
      if (flush_in && dn_valid_out && flush_q != '1) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign stall_cnt_out = stall_q;
  assign flush_cnt_out = flush_q;
`else
  assign stall_cnt_out = '0;
  assign flush_cnt_out = '0;
`endif

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Scoreboard bench for ifid_skid_stage: a depth-2 FIFO model predicts
// readiness, ordering, flush drops and the perf counter values.
module tb_ifid_skid_stage;

  localparam int W  = 32;
  localparam int L  = 2;
  localparam int CW = 3;
`ifdef IFID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic [L*W-1:0] pc;
    logic [L*W-1:0] instr;
    logic [L-1:0]   lv;
  } grp_t;

  logic clk = 1'b0;
  logic rst_in = 1'b0;
  logic flush_in = 1'b0;
  logic up_valid_in = 1'b0;
  logic up_ready_out;
  logic [L*W-1:0] pc_in = '0;
  logic [L*W-1:0] instr_in = '0;
  logic [L-1:0] lane_valid_in = '0;
  logic dn_valid_out;
  logic dn_ready_in = 1'b0;
  logic [L*W-1:0] pc_out;
  logic [L*W-1:0] instr_out;
  logic [L-1:0] lane_valid_out;
  logic [CW-1:0] stall_cnt_out;
  logic [CW-1:0] flush_cnt_out;

  int total = 0;
  int bad = 0;

  grp_t q[$];
  bit exp_ready = 1'b0;
  bit do_flush = 1'b0;
  bit do_rel = 1'b0;
  bit stall_inc = 1'b0;
  bit flush_inc = 1'b0;
  int exp_stall = 0;
  int exp_flush = 0;
  int cnt_max = (1 << CW) - 1;

  always #5 clk = ~clk;

  ifid_skid_stage #(
    .WIDTH(W),
    .LANES(L),
    .CNT_WIDTH(CW)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .flush_in      (flush_in),
    .up_valid_in   (up_valid_in),
    .up_ready_out  (up_ready_out),
    .pc_in         (pc_in),
    .instr_in      (instr_in),
    .lane_valid_in (lane_valid_in),
    .dn_valid_out  (dn_valid_out),
    .dn_ready_in   (dn_ready_in),
    .pc_out        (pc_out),
    .instr_out     (instr_out),
    .lane_valid_out(lane_valid_out),
    .stall_cnt_out (stall_cnt_out),
    .flush_cnt_out (flush_cnt_out)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".dn_valid"}, 64'(dn_valid_out), 64'd0);
    chk({tag, ".up_ready"}, 64'(up_ready_out), 64'd1);
    chk({tag, ".pc"}, 64'(pc_out), 64'd0);
    chk({tag, ".instr"}, 64'(instr_out), 64'd0);
    chk({tag, ".lane_valid"}, 64'(lane_valid_out), 64'd0);
    chk({tag, ".stall_cnt"}, 64'(stall_cnt_out), 64'd0);
    chk({tag, ".flush_cnt"}, 64'(flush_cnt_out), 64'd0);
  endtask

  // Monitor: compare against model head, then plan the coming edge.
  always @(negedge clk) begin
    if (!rst_in) begin
      chk_reset_outputs("rst");
      exp_ready = 1'b0;
      do_flush  = 1'b0;
      do_rel    = 1'b0;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
    end else begin
      chk("up_ready", 64'(up_ready_out), 64'(q.size() < 2));
      chk("dn_valid", 64'(dn_valid_out), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("pc_out", 64'(pc_out), 64'(q[0].pc));
        chk("instr_out", 64'(instr_out), 64'(q[0].instr));
        chk("lane_valid", 64'(lane_valid_out), 64'(q[0].lv));
      end else begin
        chk("lane_valid_idle", 64'(lane_valid_out), 64'd0);
      end
      chk("stall_cnt", 64'(stall_cnt_out), 64'(exp_stall));
      chk("flush_cnt", 64'(flush_cnt_out), 64'(exp_flush));
      exp_ready = (q.size() < 2);
      do_flush  = flush_in;
      do_rel    = !flush_in && q.size() != 0 && dn_ready_in;
      stall_inc = q.size() != 0 && !dn_ready_in;
      flush_inc = flush_in && q.size() != 0;
    end
  end

  always @(posedge clk) begin
    if (do_flush) q.delete();
    else if (do_rel) void'(q.pop_front());
    if (PERF && stall_inc && exp_stall < cnt_max) exp_stall++;
    if (PERF && flush_inc && exp_flush < cnt_max) exp_flush++;
  end

  // Stimulus side of the scoreboard: record every accepted group.
  always @(posedge clk) begin
    if (rst_in && up_valid_in && exp_ready && !flush_in) begin
      q.push_back('{pc: pc_in, instr: instr_in, lv: lane_valid_in});
    end
  end

  task automatic step(input bit uv, input logic [W-1:0] pc0,
                      input logic [L-1:0] lv, input bit dr,
                      input bit fl);
    @(posedge clk);
    #1;
    up_valid_in   = uv;
    pc_in         = {pc0 + 32'd4, pc0};
    instr_in      = {~pc0, pc0 ^ 32'h1357_9bdf};
    lane_valid_in = lv;
    dn_ready_in   = dr;
    flush_in      = fl;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    up_valid_in = 1'b0;
    dn_ready_in = 1'b0;
    flush_in    = 1'b0;
    rst_in      = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    q.delete();
    exp_stall = 0;
    exp_flush = 0;
    @(posedge clk);
    #3;
    rst_in = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #3;
    rst_in = 1'b1;

    // back-to-back flow
    step(1, 32'h100, 2'b11, 1, 0);
    step(1, 32'h108, 2'b01, 1, 0);
    step(1, 32'h110, 2'b10, 1, 0);
    step(0, 32'h0, 2'b00, 1, 0);
    step(0, 32'h0, 2'b00, 1, 0);

    // stall into FULL, then drain in order
    step(1, 32'h200, 2'b11, 0, 0);
    step(1, 32'h208, 2'b11, 0, 0);
    step(0, 32'h0, 2'b00, 0, 0);
    step(0, 32'h0, 2'b00, 1, 0);
    step(0, 32'h0, 2'b00, 1, 0);
    step(0, 32'h0, 2'b00, 1, 0);

    // flush while FULL with a group offered
    step(1, 32'h280, 2'b11, 0, 0);
    step(1, 32'h288, 2'b00, 0, 0);
    step(1, 32'h300, 2'b11, 0, 1);
    step(0, 32'h0, 2'b00, 1, 0);
    @(negedge clk);
    chk("post_flush_valid", 64'(dn_valid_out), 64'd0);
    chk("post_flush_lv", 64'(lane_valid_out), 64'd0);
    chk("post_flush_ready", 64'(up_ready_out), 64'd1);

    // reset asserted in the middle of a stall
    step(1, 32'h400, 2'b11, 0, 0);
    step(1, 32'h408, 2'b11, 0, 0);
    step(0, 32'h0, 2'b00, 0, 0);
    do_reset();

    // counters: 5 stalls, flush with data, flush while empty
    step(1, 32'h500, 2'b11, 0, 0);
    repeat (5) step(0, 32'h0, 2'b00, 0, 0);
    step(0, 32'h0, 2'b00, 1, 1);
    step(0, 32'h0, 2'b00, 1, 1);
    step(0, 32'h0, 2'b00, 1, 0);
    @(negedge clk);
    chk("stall_cnt_5", 64'(stall_cnt_out), PERF ? 64'd5 : 64'd0);
    chk("flush_cnt_1", 64'(flush_cnt_out), PERF ? 64'd1 : 64'd0);

    // six more stalls push the 3-bit counter to saturation
    step(1, 32'h600, 2'b01, 0, 0);
    repeat (6) step(0, 32'h0, 2'b00, 0, 0);
    step(0, 32'h0, 2'b00, 1, 0);
    step(0, 32'h0, 2'b00, 1, 0);
    @(negedge clk);
    chk("stall_cnt_sat", 64'(stall_cnt_out), PERF ? 64'd7 : 64'd0);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom,
           2'($urandom_range(0, 3)),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0);
    end
    step(0, 32'h0, 2'b00, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
